// File: rtl/mul_add_acc_uns.sv
// Sequential unsigned multiply-accumulate stage: acc = sum(x*y) over a last-terminated
// operand stream, with the result held on a valid/ready output.
// Optional feature macro: MULADDACC_SAT_EN (clamp the accumulator on overflow instead of wrapping).
module mul_add_acc_uns #(
  parameter int unsigned BW     = 8,
  parameter int unsigned widthX = BW,
  parameter int unsigned widthY = BW,
  parameter int unsigned GUARD  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [widthX-1:0]                x_i,
  input  logic [widthY-1:0]                y_i,
  input  logic                             last_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [widthX+widthY+GUARD-1:0]   acc_o,
  output logic [CNT_W-1:0]                 count_o,
  output logic                             ovf_o
);

  localparam int unsigned PROD_W = widthX + widthY;
  localparam int unsigned ACC_W  = widthX + widthY + GUARD;
  localparam int unsigned SUM_W  = ACC_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_out_valid;
  logic [ACC_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_count;
  logic                r_ovf;

  logic                r_s1_valid;
  logic                r_s1_last;
  logic [widthX-1:0]   r_s1_x;
  logic [widthY-1:0]   r_s1_y;

  logic                w_in_hs;
  logic                w_first;
  logic [PROD_W-1:0]   w_prod;
  logic [ACC_W-1:0]    w_augend;
  logic [SUM_W-1:0]    w_sum;
  logic                w_ovf_next;
  logic [ACC_W-1:0]    w_acc_next;
  logic [CNT_W-1:0]    w_count_next;

  // Accept input unless a result is held or a last term is still in flight in S1.
  assign in_ready_o = (r_state != ST_OUT) && !(r_s1_valid && r_s1_last);
  assign w_in_hs    = in_valid_i && in_ready_o;

  // S2 datapath: first term of a sequence starts from a zero augend.
  assign w_first      = (r_state == ST_IDLE);
  assign w_prod       = PROD_W'(r_s1_x) * PROD_W'(r_s1_y);
  assign w_augend     = w_first ? '0 : r_acc;
  assign w_sum        = SUM_W'(w_prod) + SUM_W'(w_augend);
  assign w_ovf_next   = (w_first ? 1'b0 : r_ovf) | w_sum[ACC_W];
  assign w_count_next = w_first ? CNT_W'(1)
                      : ((&r_count) ? r_count : r_count + CNT_W'(1));

`ifdef MULADDACC_SAT_EN
  // Once the sequence has overflowed, the accumulator stays pinned at full scale.
  assign w_acc_next = w_ovf_next ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  // Wrap modulo 2^ACC_W; overflow is still flagged.
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif

  // S1 operand register: captures on handshake, drains every cycle since S2 never stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
    end else if (clear_i) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s1_valid <= w_in_hs;
      if (w_in_hs) begin
        r_s1_last <= last_i;
        r_s1_x    <= x_i;
        r_s1_y    <= y_i;
      end
    end
  end

  // Sequence FSM with registered accumulator, counter, overflow flag and output valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
    end else if (clear_i) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ACC: begin
          if (r_s1_valid) begin
            r_acc   <= w_acc_next;
            r_count <= w_count_next;
            r_ovf   <= w_ovf_next;
            if (r_s1_last) begin
              r_state     <= ST_OUT;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_ACC;
            end
          end
        end
        ST_OUT: begin
          if (out_ready_i) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid_o = r_out_valid;
  assign acc_o       = r_acc;
  assign count_o     = r_count;
  assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_mul_add_acc_uns.sv
// Self-checking bench for mul_add_acc_uns: directed scenarios with literal results plus
// randomized sequences checked against a sum-of-products reference model.
module tb_mul_add_acc_uns;

  localparam int unsigned ACC_W = 20;
  localparam int unsigned CNT_W = 8;
  localparam longint ACC_MOD = 64'd1 << ACC_W;
  localparam longint ACC_MAX = ACC_MOD - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef MULADDACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             clear_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [7:0]       x_i;
  logic [7:0]       y_i;
  logic             last_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [ACC_W-1:0] acc_o;
  logic [CNT_W-1:0] count_o;
  logic             ovf_o;

  mul_add_acc_uns dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .x_i         (x_i),
    .y_i         (y_i),
    .last_i      (last_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .acc_o       (acc_o),
    .count_o     (count_o),
    .ovf_o       (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish within 5ms");
    $fatal(1);
  end

  typedef struct {
    longint acc;
    int     cnt;
    bit     ovf;
  } res_t;

  int     errors = 0;
  int     checks = 0;

  // Reference model: the whole sequence reduces to the true sum of products and a term count.
  res_t   exp_q[$];
  longint m_total = 0;
  int     m_n = 0;

  // Monitor bookkeeping.
  int     cyc = 0;
  int     last_cyc = 0;
  bit     have_last = 0;
  bit     prev_valid = 0;
  bit     hold_prev = 0;
  longint p_acc = 0;
  longint p_cnt = 0;
  longint p_ovf = 0;
  bit     g_in_hs = 0;
  int     n_results = 0;
  longint got_acc = 0;
  longint got_cnt = 0;
  longint got_ovf = 0;

  bit     rand_ready = 0;
  bit     rand_clear = 0;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic res_t model_result(longint total, int n);
    res_t r;
    r.ovf = (total >= ACC_MOD);
    if (SAT) r.acc = r.ovf ? ACC_MAX : total;
    else     r.acc = total % ACC_MOD;
    r.cnt = (n > CNT_MAX) ? CNT_MAX : n;
    return r;
  endfunction

  function automatic void flush_model();
    exp_q.delete();
    m_total   = 0;
    m_n       = 0;
    have_last = 0;
  endfunction

  // Per-cycle observation at the falling edge: inputs and outputs are stable here.
  task automatic monitor_step();
    res_t e;
    cyc++;
    g_in_hs = in_valid_i && in_ready_o;
    if (!rst_ni || clear_i) begin
      flush_model();
    end else begin
      if (out_valid_o) chk("in_ready_low_while_holding", in_ready_o, 0);
      if (hold_prev) begin
        chk("hold_valid", out_valid_o, 1);
        chk("hold_acc", acc_o, p_acc);
        chk("hold_count", count_o, p_cnt);
        chk("hold_ovf", ovf_o, p_ovf);
      end
      if (out_valid_o && !prev_valid && have_last) begin
        chk("latency_last_to_valid", cyc - last_cyc, 2);
        have_last = 0;
      end
      if (out_valid_o && out_ready_i) begin
        chk("result_pending", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("acc", acc_o, e.acc);
          chk("count", count_o, e.cnt);
          chk("ovf", ovf_o, e.ovf);
        end
        got_acc = acc_o;
        got_cnt = count_o;
        got_ovf = ovf_o;
        n_results++;
      end
      if (in_valid_i && in_ready_o) begin
        m_total += longint'(x_i) * longint'(y_i);
        m_n++;
        if (last_i) begin
          exp_q.push_back(model_result(m_total, m_n));
          m_total   = 0;
          m_n       = 0;
          last_cyc  = cyc;
          have_last = 1;
        end
      end
    end
    prev_valid = out_valid_o;
    hold_prev  = out_valid_o && !out_ready_i && rst_ni && !clear_i;
    p_acc = acc_o;
    p_cnt = count_o;
    p_ovf = ovf_o;
  endtask

  // One clock: observe at negedge, then update random controls just after the rising edge.
  task automatic tick();
    @(negedge clk_i);
    monitor_step();
    @(posedge clk_i);
    #1;
    clear_i = rand_clear && ($urandom_range(0, 99) == 0);
    if (rand_ready) out_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input int x, input int y, input bit last);
    int b;
    in_valid_i = 1'b1;
    x_i    = 8'(x);
    y_i    = 8'(y);
    last_i = last;
    b = 0;
    do begin
      tick();
      b++;
    end while (!g_in_hs && b < 500);
    chk("in_accept", g_in_hs, 1);
    in_valid_i = 1'b0;
    last_i     = 1'b0;
  endtask

  task automatic wait_result(input string name, input int base);
    int b;
    b = 0;
    while (n_results == base && b < 200) begin
      tick();
      b++;
    end
    chk(name, (n_results != base) ? 1 : 0, 1);
  endtask

  task automatic wait_valid(input string name);
    int b;
    b = 0;
    while (!out_valid_o && b < 50) begin
      tick();
      b++;
    end
    chk(name, out_valid_o, 1);
  endtask

  initial begin
    int base;
    int len;
    int b;
    rst_ni      = 1'b0;
    clear_i     = 1'b0;
    in_valid_i  = 1'b0;
    x_i         = '0;
    y_i         = '0;
    last_i      = 1'b0;
    out_ready_i = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_acc", acc_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_ovf", ovf_o, 0);
    rst_ni = 1'b1;
    tick();
    chk("rst_in_ready", in_ready_o, 1);

    // Single max term.
    base = n_results;
    send(255, 255, 1);
    wait_result("t1_arrived", base);
    chk("t1_acc", got_acc, 65025);
    chk("t1_count", got_cnt, 1);
    chk("t1_ovf", got_ovf, 0);

    // Three back-to-back terms.
    base = n_results;
    send(2, 3, 0);
    send(4, 5, 0);
    send(10, 10, 1);
    wait_result("t2_arrived", base);
    chk("t2_acc", got_acc, 126);
    chk("t2_count", got_cnt, 3);
    chk("t2_ovf", got_ovf, 0);

    // Seventeen max terms overflow the 20-bit accumulator.
    base = n_results;
    for (int i = 0; i < 17; i++) send(255, 255, (i == 16));
    wait_result("t3_arrived", base);
    chk("t3_acc", got_acc, SAT ? 1048575 : 56849);
    chk("t3_count", got_cnt, 17);
    chk("t3_ovf", got_ovf, 1);

    // Term counter saturates instead of wrapping.
    base = n_results;
    for (int i = 0; i < 300; i++) send(1, 1, (i == 299));
    wait_result("tsat_arrived", base);
    chk("tsat_acc", got_acc, 300);
    chk("tsat_count", got_cnt, 255);
    chk("tsat_ovf", got_ovf, 0);

    // Backpressure: result held, inputs ignored, release reopens the input next cycle.
    out_ready_i = 1'b0;
    base = n_results;
    send(1, 2, 1);
    wait_valid("t4_valid");
    in_valid_i = 1'b1;
    x_i    = 8'd9;
    y_i    = 8'd9;
    last_i = 1'b1;
    repeat (5) tick();
    chk("t4_held_valid", out_valid_o, 1);
    chk("t4_in_ready_low", in_ready_o, 0);
    in_valid_i  = 1'b0;
    last_i      = 1'b0;
    out_ready_i = 1'b1;
    tick();
    chk("t4_in_ready_after", in_ready_o, 1);
    chk("t4_valid_after", out_valid_o, 0);
    chk("t4_one_result", n_results - base, 1);
    chk("t4_acc", got_acc, 2);
    chk("t4_count", got_cnt, 1);

    // Abort mid-sequence: the pair presented with clear is discarded, no result appears.
    send(7, 7, 0);
    send(3, 3, 0);
    in_valid_i = 1'b1;
    x_i     = 8'd9;
    y_i     = 8'd9;
    last_i  = 1'b0;
    clear_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    base = n_results;
    repeat (4) tick();
    chk("t5_no_result", n_results, base);
    chk("t5_no_valid", out_valid_o, 0);
    send(1, 1, 1);
    wait_result("t5_arrived", base);
    chk("t5_acc", got_acc, 1);
    chk("t5_count", got_cnt, 1);
    chk("t5_ovf", got_ovf, 0);

    // Async reset while holding a result clears outputs without a clock edge.
    out_ready_i = 1'b0;
    send(5, 5, 1);
    wait_valid("t6_valid");
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("t6_valid_cleared", out_valid_o, 0);
    chk("t6_acc_cleared", acc_o, 0);
    chk("t6_count_cleared", count_o, 0);
    repeat (2) tick();
    rst_ni      = 1'b1;
    out_ready_i = 1'b1;
    tick();
    chk("t6_in_ready", in_ready_o, 1);
    chk("t6_no_valid", out_valid_o, 0);

    // Randomized sequences with random backpressure, gaps and occasional aborts.
    rand_ready = 1'b1;
    rand_clear = 1'b1;
    for (int s = 0; s < 40; s++) begin
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        send(($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255),
             ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255),
             (k == len - 1));
        if ($urandom_range(0, 3) == 0) tick();
      end
    end

    // Drain whatever is still pending.
    rand_clear  = 1'b0;
    rand_ready  = 1'b0;
    clear_i     = 1'b0;
    out_ready_i = 1'b1;
    b = 0;
    while ((exp_q.size() > 0 || out_valid_o) && b < 100) begin
      tick();
      b++;
    end
    chk("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
